// File: rtl/mem_access_pkg.sv
// Shared encodings and alignment rule for the memory-access stage.
package mem_access_pkg;

   typedef enum logic [2:0] {
      LD_LB   = 3'b000,
      LD_LH   = 3'b001,
      LD_LW   = 3'b010,
      LD_LBU  = 3'b100,
      LD_LHU  = 3'b101,
      LD_NONE = 3'b111
   } load_mode_t;

   typedef enum logic [1:0] {
      ST_NONE = 2'b00,
      ST_SB   = 2'b01,
      ST_SH   = 2'b10,
      ST_SW   = 2'b11
   } store_mode_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUS  = 2'b01,
      S_WB   = 2'b10
   } state_t;

   // Undefined load encodings fall through to word rules.
   function automatic logic is_misaligned(input logic       is_store,
                                          input logic [1:0] st_mode,
                                          input logic [2:0] ld_mode,
                                          input logic [1:0] offset);
      logic mis;
      mis = 1'b0;
      if (is_store) begin
         case (st_mode)
            ST_SH:   mis = offset[0];
            ST_SW:   mis = (offset != 2'b00);
            default: mis = 1'b0;
         endcase
      end else begin
         case (ld_mode)
            LD_LB, LD_LBU: mis = 1'b0;
            LD_LH, LD_LHU: mis = offset[0];
            default:       mis = (offset != 2'b00);
         endcase
      end
      return mis;
   endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-bus req/ack handshake between the memory stage and the memory system.
interface mem_access_if #(
   parameter int XLEN = 32
);
   logic            bus_req;
   logic            bus_we;
   logic [XLEN-1:0] bus_addr;
   logic [XLEN-1:0] bus_wdata;
   logic [3:0]      bus_wstrb;
   logic            bus_ack;
   logic [XLEN-1:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/mem_access_lane_align.sv
// Combinational byte-lane steering: store strobes/data and load select/extend.
module mem_lane_align
   import mem_access_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      store_mode,
   input  logic [2:0]      load_mode,
   input  logic [1:0]      offset,
   input  logic [XLEN-1:0] store_data,
   input  logic [XLEN-1:0] rdata,
   output logic [3:0]      wstrb,
   output logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] load_data
);
   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   assign rbyte = rdata[{offset, 3'b000} +: 8];
   assign rhalf = rdata[{offset[1], 4'b0000} +: 16];

   always_comb begin
      wstrb = '0;
      wdata = '0;
      case (store_mode)
         ST_SB: begin
            wstrb = 4'b0001 << offset;
            wdata = {(XLEN/8){store_data[7:0]}};
         end
         ST_SH: begin
            wstrb = 4'b0011 << offset;
            wdata = {(XLEN/16){store_data[15:0]}};
         end
         ST_SW: begin
            wstrb = 4'b1111;
            wdata = store_data;
         end
         default: ;
      endcase
   end

   always_comb begin
      load_data = rdata;
      case (load_mode)
         LD_LB:   load_data = {{(XLEN-8){rbyte[7]}}, rbyte};
         LD_LBU:  load_data = {{(XLEN-8){1'b0}}, rbyte};
         LD_LH:   load_data = {{(XLEN-16){rhalf[15]}}, rhalf};
         LD_LHU:  load_data = {{(XLEN-16){1'b0}}, rhalf};
         default: load_data = rdata;
      endcase
   end
endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: one bus transaction per load/store request,
// with timeout abort, alignment rejection and load writeback.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int TIMEOUT  = 16,
   parameter int TO_WIDTH = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        mem_load_mode,
   input  logic [XLEN-1:0]   mem_load_addr,
   input  logic [4:0]        mem_load_regs_addr,
   input  logic [1:0]        mem_store_mode,
   input  logic [XLEN-1:0]   mem_store_addr,
   input  logic [XLEN-1:0]   mem_store_data,
   mem_access_if.master      bus,
   output logic              regs_write_en,
   output logic [4:0]        regs_write_addr,
   output logic [XLEN-1:0]   regs_write_data,
   output logic              pause,
   output logic              misaligned,
   output logic              bus_err
);
   state_t              state;
   logic [TO_WIDTH-1:0] count;
   logic                lat_store;
   logic [1:0]          lat_st;
   logic [2:0]          lat_ld;
   logic [XLEN-1:0]     lat_addr;
   logic [XLEN-1:0]     lat_data;
   logic [4:0]          lat_rd;

   logic                st_req, ld_req, any_req, req_mis;
   logic [1:0]          req_off;
   logic [3:0]          wstrb;
   logic [XLEN-1:0]     wdata, load_data;

   assign st_req  = (mem_store_mode != ST_NONE);
   assign ld_req  = (mem_load_mode != LD_NONE);
   assign any_req = st_req || ld_req;
   assign req_off = st_req ? mem_store_addr[1:0] : mem_load_addr[1:0];
   assign req_mis = is_misaligned(st_req, mem_store_mode, mem_load_mode, req_off);

   assign pause = !rst && ((state != S_IDLE) || (any_req && !req_mis));

   // Lane steering runs on latched request fields so bus outputs hold steady in BUS.
   mem_lane_align #(.XLEN(XLEN)) u_lane (
      .store_mode (lat_st),
      .load_mode  (lat_ld),
      .offset     (lat_addr[1:0]),
      .store_data (lat_data),
      .rdata      (bus.bus_rdata),
      .wstrb      (wstrb),
      .wdata      (wdata),
      .load_data  (load_data)
   );

   assign bus.bus_we    = lat_store;
   assign bus.bus_addr  = {lat_addr[XLEN-1:2], 2'b00};
   assign bus.bus_wdata = wdata;
   assign bus.bus_wstrb = wstrb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= S_IDLE;
         count           <= '0;
         lat_store       <= 1'b0;
         lat_st          <= ST_NONE;
         lat_ld          <= LD_NONE;
         lat_addr        <= '0;
         lat_data        <= '0;
         lat_rd          <= '0;
         bus.bus_req     <= 1'b0;
         regs_write_en   <= 1'b0;
         regs_write_addr <= '0;
         regs_write_data <= '0;
         misaligned      <= 1'b0;
         bus_err         <= 1'b0;
      end else begin
         misaligned    <= 1'b0;
         bus_err       <= 1'b0;
         regs_write_en <= 1'b0;
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  if (req_mis) begin
                     misaligned <= 1'b1;
                  end else begin
                     lat_store   <= st_req;
                     lat_st      <= st_req ? mem_store_mode : ST_NONE;
                     lat_ld      <= st_req ? LD_NONE : mem_load_mode;
                     lat_addr    <= st_req ? mem_store_addr : mem_load_addr;
                     lat_data    <= st_req ? mem_store_data : '0;
                     lat_rd      <= mem_load_regs_addr;
                     count       <= '0;
                     bus.bus_req <= 1'b1;
                     state       <= S_BUS;
                  end
               end
            end
            S_BUS: begin
               if (bus.bus_ack) begin
                  bus.bus_req <= 1'b0;
                  count       <= '0;
                  if (lat_store) begin
                     state <= S_IDLE;
                  end else begin
                     state           <= S_WB;
                     regs_write_en   <= (lat_rd != 5'd0);
                     regs_write_addr <= lat_rd;
                     regs_write_data <= load_data;
                  end
               end else if (count == TO_WIDTH'(TIMEOUT - 1)) begin
                  bus.bus_req <= 1'b0;
                  bus_err     <= 1'b1;
                  count       <= '0;
                  state       <= S_IDLE;
               end else begin
                  count <= count + TO_WIDTH'(1);
               end
            end
            S_WB:    state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: driver pushes expected events, negedge monitor pops and compares.
module tb_mem_access;
   localparam int XLEN    = 32;
   localparam int TIMEOUT = 16;
   localparam int EV_BUS  = 0;
   localparam int EV_REG  = 1;
   localparam int EV_MIS  = 2;
   localparam int EV_ERR  = 3;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [31:0] data;
      int          len;
   } ev_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [2:0]       mem_load_mode = 3'b111;
   logic [XLEN-1:0]  mem_load_addr = '0;
   logic [4:0]       mem_load_regs_addr = '0;
   logic [1:0]       mem_store_mode = 2'b00;
   logic [XLEN-1:0]  mem_store_addr = '0;
   logic [XLEN-1:0]  mem_store_data = '0;
   logic             regs_write_en;
   logic [4:0]       regs_write_addr;
   logic [XLEN-1:0]  regs_write_data;
   logic             pause, misaligned, bus_err;

   mem_access_if #(.XLEN(XLEN)) bus_if ();

   mem_access #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .TO_WIDTH(5)) dut (
      .clk                (clk),
      .rst                (rst),
      .mem_load_mode      (mem_load_mode),
      .mem_load_addr      (mem_load_addr),
      .mem_load_regs_addr (mem_load_regs_addr),
      .mem_store_mode     (mem_store_mode),
      .mem_store_addr     (mem_store_addr),
      .mem_store_data     (mem_store_data),
      .bus                (bus_if),
      .regs_write_en      (regs_write_en),
      .regs_write_addr    (regs_write_addr),
      .regs_write_data    (regs_write_data),
      .pause              (pause),
      .misaligned         (misaligned),
      .bus_err            (bus_err)
   );

   always #5 clk = ~clk;

   int  errors = 0;
   int  checks = 0;
   ev_t exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   logic        req_prev = 1'b0;
   logic        tracking = 1'b0;
   logic        unstable;
   int          req_len, exp_len;
   logic [31:0] s_addr, s_wdata;
   logic        s_we;
   logic [3:0]  s_wstrb;

   task automatic pop_ev(input int kind, input string nm, output ev_t e, output bit ok);
      checks++;
      ok = 1'b0;
      e  = '{default: '0};
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: unexpected event (kind %0d), none expected", nm, kind);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind) begin
            errors++;
            $display("FAIL %s: got event kind %0d expected kind %0d", nm, kind, e.kind);
         end else begin
            ok = 1'b1;
         end
      end
   endtask

   always @(negedge clk) begin
      ev_t e;
      bit  ok;
      if (rst) begin
         req_prev = 1'b0;
         tracking = 1'b0;
      end else begin
         if (bus_if.bus_req && !req_prev) begin
            pop_ev(EV_BUS, "bus_start", e, ok);
            if (ok) begin
               chk("bus_addr", bus_if.bus_addr, e.addr);
               chk("bus_we", {31'd0, bus_if.bus_we}, {31'd0, e.we});
               chk("bus_wstrb", {28'd0, bus_if.bus_wstrb}, {28'd0, e.wstrb});
               if (e.we) chk("bus_wdata", bus_if.bus_wdata, e.wdata);
            end
            tracking = 1'b1;
            unstable = 1'b0;
            req_len  = 1;
            exp_len  = ok ? e.len : -1;
            s_addr   = bus_if.bus_addr;
            s_we     = bus_if.bus_we;
            s_wstrb  = bus_if.bus_wstrb;
            s_wdata  = bus_if.bus_wdata;
         end else if (bus_if.bus_req && tracking) begin
            req_len++;
            if (bus_if.bus_addr !== s_addr || bus_if.bus_we !== s_we ||
                bus_if.bus_wstrb !== s_wstrb || bus_if.bus_wdata !== s_wdata)
               unstable = 1'b1;
         end
         if (!bus_if.bus_req && req_prev && tracking) begin
            chk("bus_stable", {31'd0, unstable}, 32'd0);
            if (exp_len >= 0) chk("req_len", req_len, exp_len);
            tracking = 1'b0;
         end
         if (bus_if.bus_req && !pause) begin
            checks++;
            errors++;
            $display("FAIL pause_in_bus: got pause 0 expected 1 while bus_req");
         end
         if (regs_write_en) begin
            pop_ev(EV_REG, "reg_write", e, ok);
            if (ok) begin
               chk("reg_addr", {27'd0, regs_write_addr}, {27'd0, e.rd});
               chk("reg_data", regs_write_data, e.data);
               chk("reg_latency", {31'd0, req_prev}, 32'd1);
               chk("pause_in_wb", {31'd0, pause}, 32'd1);
            end
         end
         if (misaligned) pop_ev(EV_MIS, "misaligned", e, ok);
         if (bus_err) begin
            pop_ev(EV_ERR, "bus_err", e, ok);
            if (ok) chk("err_after_bus", {31'd0, req_prev}, 32'd1);
         end
         req_prev = bus_if.bus_req;
      end
   end

   // ---------------- reference model + driver ----------------
   task automatic issue(input logic [1:0] st_mode, input logic [31:0] st_addr, input logic [31:0] st_data,
                        input logic [2:0] ld_mode, input logic [31:0] ld_addr, input logic [4:0] rd,
                        input int delay, input logic [31:0] rdata);
      bit          is_st, sgn, mis;
      int unsigned size, off;
      logic [31:0] a, mask, v;
      ev_t         e;
      is_st = (st_mode != 2'b00);
      a     = is_st ? st_addr : ld_addr;
      off   = a % 4;
      if (is_st) size = (st_mode == 2'd1) ? 1 : (st_mode == 2'd2) ? 2 : 4;
      else       size = (ld_mode == 3'd0 || ld_mode == 3'd4) ? 1 :
                        (ld_mode == 3'd1 || ld_mode == 3'd5) ? 2 : 4;
      sgn = !is_st && (ld_mode == 3'd0 || ld_mode == 3'd1);
      mis = (a % size) != 0;

      @(posedge clk); #1;
      mem_store_mode = st_mode;  mem_store_addr = st_addr;  mem_store_data = st_data;
      mem_load_mode  = ld_mode;  mem_load_addr  = ld_addr;  mem_load_regs_addr = rd;
      bus_if.bus_rdata = rdata;

      e = '{default: '0};
      if (mis) begin
         e.kind = EV_MIS;
         exp_q.push_back(e);
      end else begin
         e.kind  = EV_BUS;
         e.addr  = a & 32'hFFFF_FFFC;
         e.we    = is_st;
         e.wstrb = is_st ? 4'(((32'd1 << size) - 1) << off) : 4'd0;
         e.wdata = (size == 1) ? st_data[7:0] * 32'h0101_0101 :
                   (size == 2) ? st_data[15:0] * 32'h0001_0001 : st_data;
         e.len   = (delay < TIMEOUT) ? delay + 1 : TIMEOUT;
         exp_q.push_back(e);
         if (delay >= TIMEOUT) begin
            e = '{default: '0};
            e.kind = EV_ERR;
            exp_q.push_back(e);
         end else if (!is_st && rd != 5'd0) begin
            mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 1;
            v    = (rdata >> (8 * off)) & mask;
            if (sgn && v[8*size-1]) v = v | ~mask;
            e = '{default: '0};
            e.kind = EV_REG;
            e.rd   = rd;
            e.data = v;
            exp_q.push_back(e);
         end
      end
      #1 chk("pause_on_request", {31'd0, pause}, {31'd0, !mis});

      @(posedge clk); #1;
      mem_store_mode = 2'b00;
      mem_load_mode  = 3'b111;
      if (mis) begin
         chk("pause_after_misaligned", {31'd0, pause}, 32'd0);
      end else begin
         for (int k = 0; k < TIMEOUT; k++) begin
            if (k == delay) bus_if.bus_ack = 1'b1;
            @(posedge clk); #1;
            bus_if.bus_ack = 1'b0;
            if (k == delay) break;
         end
         for (int w = 0; w < 8 && pause; w++) begin
            @(posedge clk); #1;
         end
         if (pause) begin
            checks++;
            errors++;
            $display("FAIL pause_release: got pause 1 expected 0 within 8 cycles");
         end
      end
   endtask

   initial begin
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_rdata = '0;
      #2;
      chk("rst_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
      chk("rst_bus_we", {31'd0, bus_if.bus_we}, 32'd0);
      chk("rst_wstrb", {28'd0, bus_if.bus_wstrb}, 32'd0);
      chk("rst_bus_addr", bus_if.bus_addr, 32'd0);
      chk("rst_regs_we", {31'd0, regs_write_en}, 32'd0);
      chk("rst_pause", {31'd0, pause}, 32'd0);
      chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
      chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // directed cases
      issue(2'b11, 32'h100, 32'hDEAD_BEEF, 3'b111, 32'h0, 5'd0, 2, 32'h0);
      issue(2'b00, 32'h0, 32'h0, 3'b000, 32'h203, 5'd5, 0, 32'h8011_2233);
      issue(2'b00, 32'h0, 32'h0, 3'b100, 32'h203, 5'd5, 0, 32'h8011_2233);
      issue(2'b00, 32'h0, 32'h0, 3'b001, 32'h202, 5'd6, 1, 32'h8001_1234);
      issue(2'b10, 32'h202, 32'h0000_ABCD, 3'b111, 32'h0, 5'd0, 0, 32'h0);
      issue(2'b00, 32'h0, 32'h0, 3'b010, 32'h102, 5'd3, 0, 32'h0);
      issue(2'b01, 32'h101, 32'h0000_005A, 3'b111, 32'h0, 5'd0, 0, 32'h0);
      issue(2'b00, 32'h0, 32'h0, 3'b010, 32'h108, 5'd9, TIMEOUT, 32'h1234_5678);
      issue(2'b00, 32'h0, 32'h0, 3'b010, 32'h10C, 5'd9, TIMEOUT - 1, 32'hCAFE_F00D);
      issue(2'b11, 32'h110, 32'h0BAD_CAFE, 3'b010, 32'h114, 5'd4, 0, 32'h0);
      issue(2'b00, 32'h0, 32'h0, 3'b011, 32'h118, 5'd8, 0, 32'h7654_3210);
      issue(2'b00, 32'h0, 32'h0, 3'b110, 32'h11D, 5'd8, 0, 32'h0);
      issue(2'b10, 32'h121, 32'h1111, 3'b111, 32'h0, 5'd0, 0, 32'h0);

      // asynchronous reset mid-transaction
      begin
         ev_t e;
         @(posedge clk); #1;
         mem_load_mode = 3'b010;  mem_load_addr = 32'h300;  mem_load_regs_addr = 5'd7;
         e = '{default: '0};
         e.kind = EV_BUS;  e.addr = 32'h300;  e.len = -1;
         exp_q.push_back(e);
         @(posedge clk); #1;
         mem_load_mode = 3'b111;
         repeat (3) @(posedge clk);
         #3 rst = 1'b1;
         #1;
         chk("async_rst_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
         chk("async_rst_pause", {31'd0, pause}, 32'd0);
         repeat (2) @(posedge clk);
         #1 rst = 1'b0;
      end
      issue(2'b00, 32'h0, 32'h0, 3'b010, 32'h304, 5'd0, 0, 32'hFFFF_FFFF);

      // randomized traffic
      for (int n = 0; n < 60; n++) begin
         logic [2:0]  lm;
         logic [1:0]  sm;
         logic [31:0] ad;
         int          dl;
         logic [2:0]  lmodes [7];
         lmodes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
         lm = lmodes[$urandom_range(0, 6)];
         sm = 2'($urandom_range(1, 3));
         ad = 32'h400 + 32'($urandom_range(0, 63));
         dl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0)
            issue(2'b00, 32'h0, 32'h0, lm, ad, 5'($urandom_range(0, 31)), dl, $urandom);
         else
            issue(sm, ad, $urandom, 3'b111, 32'h0, 5'd0, dl, $urandom);
      end

      repeat (3) @(posedge clk);
      #1 chk("queue_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Pipeline stage directly downstream of execution; consumes the load/store requests that execution produces.
- Performs one data-bus transaction per request with a req/ack handshake, a timeout, and byte-lane steering.
- On loads, writes the extended result to the register file.
- Holds the pipeline paused while a transaction is outstanding.

Parameters:
- XLEN, 32, data/address width.
- TIMEOUT, 16, maximum wait cycles for bus_ack before abort (>=1).
- TO_WIDTH, 5, timeout counter width (must hold TIMEOUT).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- mem_load_mode  in  3  funct3 of the load; 3'b111 = no load.
- mem_load_addr  in  XLEN  load byte address.
- mem_load_regs_addr  in  5  load destination register.
- mem_store_mode  in  2  00 none, 01 SB, 10 SH, 11 SW.
- mem_store_addr  in  XLEN  store byte address.
- mem_store_data  in  XLEN  store data, low-aligned.
- bus_req  out  1  transaction request.
- bus_we  out  1  1 = write.
- bus_addr  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00}).
- bus_wdata  out  XLEN  lane-shifted store data.
- bus_wstrb  out  4  byte enables.
- bus_ack  in  1  transaction complete; bus_rdata valid on reads.
- bus_rdata  in  XLEN  read word.
- regs_write_en  out  1  register write strobe.
- regs_write_addr  out  5  destination register.
- regs_write_data  out  XLEN  extended load data.
- pause  out  1  stall request to fetch/decode/execute.
- misaligned  out  1  one-cycle pulse: request rejected for alignment.
- bus_err  out  1  one-cycle pulse: timeout abort.

Behaviour:
- Reset: all outputs 0; state IDLE; counter 0.
- Asynchronous assertion mid-transaction drops bus_req immediately; no writeback occurs.
- States: IDLE, BUS, WB.
- IDLE:
  - Request = store_mode!=00 or load_mode!=111.
  - pause is driven combinationally high in the cycle a request is present.
  - At the edge, the block latches addr, mode, data, rd and goes to BUS.
  - Store and load both present: the store is taken and the load is dropped (execution never issues both).
- Alignment is checked in IDLE:
  - H/HU/SH with addr[0]=1 → misaligned.
  - W/SW with addr[1:0]!=0 → misaligned.
  - Misaligned: pulse misaligned the next cycle, stay IDLE, no bus activity.
- Unsupported load_mode values (011, 110): treated as LW.
- BUS:
  - bus_req=1, registered; high from the cycle after capture.
  - bus_addr, bus_we, bus_wdata and bus_wstrb are stable while bus_req=1.
  - Store lanes:
    - SB: wstrb = 0001<<addr[1:0], wdata = {4{data[7:0]}}.
    - SH: wstrb = 0011<<addr[1:0], wdata = {2{data[15:0]}}.
    - SW: wstrb = 1111.
  - Loads: wstrb = 0000.
  - Counter increments each BUS cycle without ack.
  - bus_ack=1:
    - Load → WB; rdata is captured and extended.
    - Store → IDLE.
  - Counter reaches TIMEOUT-1 with no ack → IDLE, pulse bus_err, no writeback.
  - Ack in the same cycle as timeout: ack wins.
- Load extension (byte/half selected by addr[1:0]):
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- WB:
  - regs_write_en=1 for exactly one cycle with the latched rd and data, then IDLE.
  - rd=0: regs_write_en stays 0; the bus read is still performed.
- pause = (state!=IDLE) or (IDLE and valid aligned request). It drops in the cycle after WB (loads) or after the acked BUS cycle (stores).
- Minimum latency with ack on the first BUS cycle:
  - Load: capture edge → BUS 1 cycle → WB 1 cycle.
  - Store: capture edge → BUS 1 cycle.
- No new request is sampled outside IDLE.

Decomposition:
- Shared constants package/define file holds:
  - Load mode encodings (LB 000, LH 001, LW 010, LBU 100, LHU 101, NONE 111).
  - Store mode encodings.
  - State encodings.
- Single sub-module mem_lane_align (combinational):
  - Store path: wstrb/wdata generation.
  - Load path: byte/half select plus extension.
  - Reused by future cache/uncached paths.

Test Plan:
- SW addr 0x100 data 0xDEADBEEF, ack after 2 cycles → bus_addr 0x100, wstrb 1111, wdata 0xDEADBEEF, req held 3 cycles, pause high throughout, no reg write.
- LB addr 0x203 rd=5, rdata 0x80112233, ack immediate → regs_write_en one cycle, addr 5, data 0xFFFFFF80; LBU same → 0x00000080.
- LH addr 0x202, rdata 0x8001_1234 → data 0xFFFF8001; SH addr 0x202 data 0xABCD → wstrb 1100, wdata 0xABCDABCD.
- LW addr 0x102 → misaligned pulse, bus_req never asserted, pause low next cycle; SB addr 0x101 → wstrb 0010 (no misalignment).
- Load, no ack, TIMEOUT=16 → bus_req 16 cycles, then bus_err pulse, IDLE, regs_write_en never asserted.
- rst asserted during BUS → bus_req and pause 0 asynchronously; after release, a new LW rd=0 completes with no register write.
